// File: rtl/p405s_icu_vb_ctrl_pkg.sv
// Shared ICU valid-bit controller definitions.
// Holds the index width, way count, FSM encodings and a way-select helper.
package p405s_icu_vb_ctrl_pkg;

    localparam int IDX_W = 5;
    localparam int WAYS  = 2;
    localparam int VB_W  = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLASH_WR = 2'd1,
        INV_WR   = 2'd2,
        FILL_WR  = 2'd3
    } vbState_e;

    // Single-way select to a [0:1] way mask (bit 0 = way A).
    function automatic logic [0:WAYS-1] wayToMask(input logic way);
        return {~way, way};
    endfunction

endpackage

// File: rtl/p405s_icu_vb_ctrl_if.sv
// Request/ack and debug bundle of the ICU valid-bit controller.
// master = requester/observer side, slave = controller side.
interface p405s_icu_vb_ctrl_if;
    import p405s_icu_vb_ctrl_pkg::*;

    logic                    fillReq;
    logic [4:4+IDX_W-1]      fillIndex;
    logic                    fillWay;
    logic                    fillAck;
    logic                    invReq;
    logic [4:4+IDX_W-1]      invIndex;
    logic [0:WAYS-1]         invWayMask;
    logic                    invAck;
    logic                    flashReq;
    logic                    flashDone;
    logic [4:4+IDX_W-1]      lkIndex;
    logic [0:WAYS-1]         lkVb;
    logic                    busy;
    logic [0:VB_W-1]         vbA;
    logic [0:VB_W-1]         vbB;

    modport master (
        output fillReq, fillIndex, fillWay,
        output invReq, invIndex, invWayMask,
        output flashReq, lkIndex,
        input  fillAck, invAck, flashDone,
        input  lkVb, busy, vbA, vbB
    );

    modport slave (
        input  fillReq, fillIndex, fillWay,
        input  invReq, invIndex, invWayMask,
        input  flashReq, lkIndex,
        output fillAck, invAck, flashDone,
        output lkVb, busy, vbA, vbB
    );

endinterface

// File: rtl/p405s_icu_vb_ctrl_newVbGen.sv
// Next-value generator for one way's valid array.
// Ports: feedbackVb (current array), wrFlash, vbWrIndex, newVbBit -> newVb.
module p405s_icu_newVbGen
    import p405s_icu_vb_ctrl_pkg::*;
(
    input  logic [0:VB_W-1]     feedbackVb,
    input  logic                wrFlash,
    input  logic [4:4+IDX_W-1]  vbWrIndex,
    input  logic                newVbBit,
    output logic [0:VB_W-1]     newVb
);

    always_comb begin
        newVb = feedbackVb;
        if (wrFlash) begin
            newVb = '0;
        end else begin
            newVb[vbWrIndex] = newVbBit;
        end
    end

endmodule

// File: rtl/p405s_icu_vb_ctrl.sv
// ICU valid-bit controller: serialises fill, icbi and iccci writes.
// Ports: CB, resetN (sync, active-low), bus (slave side of the ICU bundle).
module p405s_icu_vb_ctrl
    import p405s_icu_vb_ctrl_pkg::*;
(
    input  logic                 CB,
    input  logic                 resetN,
    p405s_icu_vb_ctrl_if.slave   bus
);

    vbState_e              state;
    vbState_e              stateNxt;
    logic                  flashPend;
    logic                  flashPendNxt;
    logic [4:4+IDX_W-1]    holdIndex;
    logic [4:4+IDX_W-1]    holdIndexNxt;
    logic [0:WAYS-1]       holdMask;
    logic [0:WAYS-1]       holdMaskNxt;
    logic                  holdFill;
    logic                  holdFillNxt;
    logic                  fillAcc;
    logic                  invAcc;

    logic [0:VB_W-1]       vb    [0:WAYS-1];
    logic [0:VB_W-1]       newVb [0:WAYS-1];
    logic [0:WAYS-1]       wayWr;

    // Arbitration and next state; requests are only taken in IDLE.
    always_comb begin
        stateNxt     = state;
        flashPendNxt = flashPend;
        holdIndexNxt = holdIndex;
        holdMaskNxt  = holdMask;
        holdFillNxt  = holdFill;
        fillAcc      = 1'b0;
        invAcc       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.flashReq || flashPend) begin
                    stateNxt     = FLASH_WR;
                    flashPendNxt = 1'b0;
                end else if (bus.invReq) begin
                    stateNxt     = INV_WR;
                    invAcc       = 1'b1;
                    holdIndexNxt = bus.invIndex;
                    holdMaskNxt  = bus.invWayMask;
                    holdFillNxt  = 1'b0;
                end else if (bus.fillReq) begin
                    stateNxt     = FILL_WR;
                    fillAcc      = 1'b1;
                    holdIndexNxt = bus.fillIndex;
                    holdMaskNxt  = wayToMask(bus.fillWay);
                    holdFillNxt  = 1'b1;
                end
            end
            default: begin
                // Every WR state is a single cycle; flashes seen meanwhile
                // collapse into one pending flash.
                stateNxt = IDLE;
                if (bus.flashReq) begin
                    flashPendNxt = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CB) begin
        if (!resetN) begin
            state     <= IDLE;
            flashPend <= 1'b0;
            holdIndex <= '0;
            holdMask  <= '0;
            holdFill  <= 1'b0;
        end else begin
            state     <= stateNxt;
            flashPend <= flashPendNxt;
            holdIndex <= holdIndexNxt;
            holdMask  <= holdMaskNxt;
            holdFill  <= holdFillNxt;
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : gWay
        assign wayWr[w] = (state == FLASH_WR) ||
                          (((state == INV_WR) || (state == FILL_WR)) &&
                           holdMask[w]);

        p405s_icu_newVbGen uGen (
            .feedbackVb (vb[w]),
            .wrFlash    (state == FLASH_WR),
            .vbWrIndex  (holdIndex),
            .newVbBit   (holdFill),
            .newVb      (newVb[w])
        );

        always_ff @(posedge CB) begin
            if (!resetN) begin
                vb[w] <= '0;
            end else if (wayWr[w]) begin
                vb[w] <= newVb[w];
            end
        end
    end

    // Pulses are masked while reset is held so nothing leaks out of reset.
    assign bus.fillAck   = fillAcc && resetN;
    assign bus.invAck    = invAcc && resetN;
    assign bus.flashDone = (state == FLASH_WR) && resetN;
    assign bus.busy      = (state != IDLE) || flashPend;
    assign bus.vbA       = vb[0];
    assign bus.vbB       = vb[1];
    assign bus.lkVb      = {vb[0][bus.lkIndex], vb[1][bus.lkIndex]};

endmodule

// File: tb/tb_p405s_icu_vb_ctrl.sv
// Self-checking bench for the ICU valid-bit controller.
// Directed vector table plus hand-written multi-cycle sequences.
module tb_p405s_icu_vb_ctrl;
    import p405s_icu_vb_ctrl_pkg::*;

    logic CB = 1'b0;
    logic resetN;
    always #5 CB = ~CB;

    p405s_icu_vb_ctrl_if bus ();

    p405s_icu_vb_ctrl dut (
        .CB     (CB),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          kind;   // 0 fill, 1 inv, 2 flash
        logic [4:0]  idx;
        logic        way;
        logic [0:1]  mask;
        logic [4:0]  lk;
        logic [31:0] expA;
        logic [31:0] expB;
        logic [1:0]  expLk;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(int k, logic [4:0] i, logic w,
                                logic [0:1] m, logic [4:0] l,
                                logic [31:0] a, logic [31:0] b,
                                logic [1:0] e);
        vec_t v;
        v.kind = k; v.idx = i; v.way = w; v.mask = m; v.lk = l;
        v.expA = a; v.expB = b; v.expLk = e;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CB);
        #1;
    endtask

    // Starts and ends just after a rising edge.
    task automatic applyVec(vec_t v, string tag);
        logic got;
        got = 1'b0;
        bus.lkIndex = v.lk;
        if (v.kind == 2) begin
            bus.flashReq = 1'b1;
            cyc();
            bus.flashReq = 1'b0;
            @(negedge CB);
            chk({tag, " flashDone"}, 32'(bus.flashDone), 32'd1);
        end else begin
            if (v.kind == 0) begin
                bus.fillReq = 1'b1;
                bus.fillIndex = v.idx;
                bus.fillWay = v.way;
            end else begin
                bus.invReq = 1'b1;
                bus.invIndex = v.idx;
                bus.invWayMask = v.mask;
            end
            for (int t = 0; t < 8 && !got; t++) begin
                @(negedge CB);
                got = (v.kind == 0) ? bus.fillAck : bus.invAck;
                cyc();
            end
            chk({tag, " ack"}, 32'(got), 32'd1);
            bus.fillReq = 1'b0;
            bus.invReq = 1'b0;
            @(negedge CB);
            chk({tag, " wr busy/noack"},
                {29'd0, bus.busy, bus.fillAck, bus.invAck}, 32'd4);
        end
        cyc();
        @(negedge CB);
        chk({tag, " vbA"}, bus.vbA, v.expA);
        chk({tag, " vbB"}, bus.vbB, v.expB);
        chk({tag, " lkVb"}, 32'(bus.lkVb), 32'(v.expLk));
        cyc();
    endtask

    // Back-to-back fills of every index in one way.
    task automatic fillAll(logic way, logic [31:0] otherExp, string tag);
        int   missed;
        logic otherBad;
        logic got;
        missed = 0;
        otherBad = 1'b0;
        bus.fillReq = 1'b1;
        bus.fillWay = way;
        for (int i = 0; i < 32; i++) begin
            bus.fillIndex = 5'(i);
            got = 1'b0;
            for (int t = 0; t < 4 && !got; t++) begin
                @(negedge CB);
                if ((way ? bus.vbA : bus.vbB) !== otherExp) otherBad = 1'b1;
                got = bus.fillAck;
                cyc();
            end
            if (!got) missed++;
        end
        bus.fillReq = 1'b0;
        cyc();
        @(negedge CB);
        chk({tag, " missed acks"}, 32'(missed), 32'd0);
        chk({tag, " other way stable"}, 32'(otherBad), 32'd0);
        chk({tag, " filled way"}, way ? bus.vbB : bus.vbA, 32'hFFFF_FFFF);
        cyc();
    endtask

    initial begin
        int fd;
        bus.fillReq = 0; bus.fillIndex = 0; bus.fillWay = 0;
        bus.invReq = 0; bus.invIndex = 0; bus.invWayMask = 0;
        bus.flashReq = 0; bus.lkIndex = 0;

        vecs[0] = mk(0, 5,  0, 2'b00, 5,  32'h0400_0000, 32'h0, 2'b10);
        vecs[1] = mk(0, 0,  1, 2'b00, 0,  32'h0400_0000, 32'h8000_0000, 2'b01);
        vecs[2] = mk(0, 31, 0, 2'b00, 31, 32'h0400_0001, 32'h8000_0000, 2'b10);
        vecs[3] = mk(0, 31, 1, 2'b00, 31, 32'h0400_0001, 32'h8000_0001, 2'b11);
        vecs[4] = mk(1, 31, 0, 2'b10, 31, 32'h0400_0000, 32'h8000_0001, 2'b01);
        vecs[5] = mk(1, 5,  0, 2'b00, 5,  32'h0400_0000, 32'h8000_0001, 2'b10);
        vecs[6] = mk(1, 0,  0, 2'b11, 0,  32'h0400_0000, 32'h0000_0001, 2'b00);
        vecs[7] = mk(1, 5,  0, 2'b01, 5,  32'h0400_0000, 32'h0000_0001, 2'b10);
        vecs[8] = mk(2, 0,  0, 2'b00, 31, 32'h0, 32'h0, 2'b00);
        vecs[9] = mk(0, 16, 1, 2'b00, 16, 32'h0, 32'h0000_8000, 2'b01);

        resetN = 1'b0;
        cyc();
        cyc();
        resetN = 1'b1;
        @(negedge CB);
        chk("reset vbA", bus.vbA, 32'h0);
        chk("reset vbB", bus.vbB, 32'h0);
        chk("reset busy/acks",
            {28'd0, bus.busy, bus.fillAck, bus.invAck, bus.flashDone}, 32'd0);
        cyc();

        for (int i = 0; i < 10; i++) begin
            applyVec(vecs[i], $sformatf("vec%0d", i));
        end

        // Clean slate, then fill way B completely while A stays zero.
        applyVec(mk(2, 0, 0, 2'b00, 0, 32'h0, 32'h0, 2'b00), "flash0");
        fillAll(1'b1, 32'h0, "fillB");
        fillAll(1'b0, 32'hFFFF_FFFF, "fillA");

        // Reset landing on an INV_WR cycle.
        bus.invReq = 1'b1; bus.invIndex = 0; bus.invWayMask = 2'b11;
        @(negedge CB);
        chk("rst invAck", 32'(bus.invAck), 32'd1);
        cyc();
        bus.invReq = 1'b0;
        resetN = 1'b0;
        @(negedge CB);
        chk("rst wr busy", 32'(bus.busy), 32'd1);
        cyc();
        resetN = 1'b1;
        @(negedge CB);
        chk("rst vbA", bus.vbA, 32'h0);
        chk("rst vbB", bus.vbB, 32'h0);
        chk("rst idle/noack",
            {28'd0, bus.busy, bus.fillAck, bus.invAck, bus.flashDone}, 32'd0);
        cyc();

        // All ones, then icbi of index 31 in both ways.
        fillAll(1'b1, 32'h0, "refillB");
        fillAll(1'b0, 32'hFFFF_FFFF, "refillA");
        applyVec(mk(1, 31, 0, 2'b11, 31, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 2'b00),
                 "inv31");

        // Fill and inv together on index 3: inv first, fill two cycles on.
        bus.lkIndex = 3;
        bus.invReq = 1'b1; bus.invIndex = 3; bus.invWayMask = 2'b11;
        bus.fillReq = 1'b1; bus.fillIndex = 3; bus.fillWay = 1'b0;
        @(negedge CB);
        chk("pri acks N", {30'd0, bus.invAck, bus.fillAck}, 32'd2);
        cyc();
        bus.invReq = 1'b0;
        @(negedge CB);
        chk("pri acks N+1", {30'd0, bus.invAck, bus.fillAck}, 32'd0);
        cyc();
        @(negedge CB);
        chk("pri acks N+2", {30'd0, bus.invAck, bus.fillAck}, 32'd1);
        chk("pri inv first", bus.vbA, 32'hEFFF_FFFE);
        cyc();
        bus.fillReq = 1'b0;
        cyc();
        @(negedge CB);
        chk("pri final vbA", bus.vbA, 32'hFFFF_FFFE);
        chk("pri final vbB", bus.vbB, 32'hEFFF_FFFE);
        chk("pri lkVb", 32'(bus.lkVb), 32'd2);
        cyc();

        // One flash pulse during FILL_WR only: must be held pending.
        bus.fillReq = 1'b1; bus.fillIndex = 7; bus.fillWay = 1'b1;
        @(negedge CB);
        chk("pend fillAck", 32'(bus.fillAck), 32'd1);
        cyc();
        bus.fillReq = 1'b0;
        bus.flashReq = 1'b1;
        cyc();
        bus.flashReq = 1'b0;
        fd = 0;
        for (int t = 0; t < 5; t++) begin
            @(negedge CB);
            if (bus.flashDone) fd++;
            cyc();
        end
        chk("pend flash count", 32'(fd), 32'd1);
        chk("pend vbA", bus.vbA, 32'h0);
        chk("pend vbB", bus.vbB, 32'h0);

        // Two flash pulses before service coalesce into one flash.
        bus.fillReq = 1'b1; bus.fillIndex = 9; bus.fillWay = 1'b0;
        @(negedge CB);
        chk("coal fillAck", 32'(bus.fillAck), 32'd1);
        cyc();
        bus.fillReq = 1'b0;
        bus.flashReq = 1'b1;
        cyc();
        @(negedge CB);
        chk("coal pend busy", 32'(bus.busy), 32'd1);
        chk("coal vbA before", bus.vbA, 32'h0040_0000);
        cyc();
        bus.flashReq = 1'b0;
        fd = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge CB);
            if (bus.flashDone) fd++;
            cyc();
        end
        chk("coal flash count", 32'(fd), 32'd1);
        chk("coal vbA", bus.vbA, 32'h0);
        chk("coal idle", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/p405s_icu_vb_ctrl.md
P405S_ICU_VB_CTRL -- requirements
Module: p405s_icu_vbCtrl

Interface
REQ-001 The block SHALL provide the following ports (name  direction  width  meaning):
- CB  in  1  core clock; all state updates on its rising edge.
- resetN  in  1  reset; synchronous, active-low.
- fillReq  in  1  line-fill requests setting one valid bit.
- fillIndex  in  [4:8]  fill congruence-class index.
- fillWay  in  1  fill way select (0 = way A, 1 = way B).
- fillAck  out  1  one-cycle pulse when the fill is accepted.
- invReq  in  1  single-line invalidate request (icbi).
- invIndex  in  [4:8]  invalidate index.
- invWayMask  in  [0:1]  ways to clear (bit 0 = A, bit 1 = B).
- invAck  out  1  one-cycle pulse when the invalidate is accepted.
- flashReq  in  1  flash-invalidate request (iccci), pulse.
- flashDone  out  1  one-cycle pulse in the cycle the flash clear is written.
- lkIndex  in  [4:8]  lookup index.
- lkVb  out  [0:1]  registered valid bits at lkIndex (way A, way B); combinational read.
- busy  out  1  high whenever state is not IDLE or a flash is pending.
- vbA, vbB  out  [0:31]  full valid-bit arrays, for debug and test.

Function
REQ-002 Each way SHALL hold a 32-bit valid register. Index i SHALL map to bit i, with bit 0 MSB-numbered.
REQ-003 The FSM SHALL have four states: IDLE, FLASH_WR, INV_WR and FILL_WR. Each WR state SHALL last exactly one cycle and then return to IDLE.
REQ-004 In IDLE, arbitration priority SHALL be flash (flashReq or flashPend), then invReq, then fillReq. Only one request SHALL be accepted per cycle.
REQ-005 Acceptance SHALL latch the index, way or mask, and kind into hold registers. The ack SHALL pulse in the same cycle as acceptance. A requester SHALL hold its req until it sees the ack.
REQ-006 Latency SHALL be as follows:
- Accept in cycle N; array write at the rising edge ending cycle N+1.
- lkVb SHALL reflect the write from cycle N+2.
REQ-007 FILL_WR SHALL set the latched index bit in the latched way only. The other way and all other bits SHALL be unchanged.
REQ-008 INV_WR SHALL clear the latched index bit in every way whose mask bit is 1. A mask of 00 SHALL be accepted and acked, with no array change.
REQ-009 FLASH_WR SHALL clear all 64 bits. flashDone SHALL pulse in the FLASH_WR cycle.
REQ-010 A flashReq arriving when the FSM is not in IDLE SHALL set flashPend. flashPend SHALL be serviced at the next IDLE cycle and cleared on entry to FLASH_WR.
REQ-011 Multiple flashReq pulses before service SHALL coalesce into a single flash.
REQ-012 When fillReq and invReq are asserted in the same IDLE cycle, inv SHALL be acked and fill SHALL stay pending. Fill SHALL be acked no earlier than 2 cycles later.
REQ-013 A fill to an index whose invalidate was accepted earlier SHALL be ordered after it, because writes are strictly serialised.
REQ-014 No ack SHALL be issued in a WR state. busy SHALL be 1 in every WR state.
REQ-015 Index arithmetic SHALL be 5-bit only. All 32 indices SHALL be legal, and there is no wrap-around.

Reset
REQ-016 While resetN=0 at a rising edge of CB, the block SHALL set:
- state = IDLE, flashPend = 0;
- vbA = vbB = 0;
- fillAck = invAck = flashDone = 0;
- hold registers = 0.
REQ-017 Reset asserted mid-operation SHALL abort any in-flight write. No ack or done SHALL pulse in the cycle after reset deasserts unless a request is present then.
REQ-018 Reset SHALL take priority over all requests.

Structure
REQ-019 The state encodings (2-bit), the way count (2) and the index width (5) SHALL reside in the shared ICU package and be used by this block.
REQ-020 One p405s_icu_newVbGen instance per way SHALL compute the next array:
- feedbackVb = that way's register;
- wrFlash = FLASH_WR;
- vbWrIndex = latched index;
- newVbBit = 1 for fill, 0 for inv.
REQ-021 A way's register SHALL load the newVbGen output only when that way is written in the current WR state.

Verification
REQ-022 Scenario: after reset, fillReq index 5 way A -> fillAck in cycle N; vbA = 0x04000000 at N+2; vbB = 0.
REQ-023 Scenario: with vbA = vbB = 0xFFFFFFFF, invReq index 31 mask 11 -> both arrays = 0xFFFFFFFE; lkIndex=31 gives lkVb = 00 at N+2.
REQ-024 Scenario: fillReq and invReq asserted together (index 3) -> invAck first, fillAck 2 cycles later; final bit 3 set in the fill way.
REQ-025 Scenario: flashReq pulsed twice during FILL_WR -> exactly one FLASH_WR follows; flashDone pulses once; arrays = 0.
REQ-026 Scenario: resetN low during INV_WR, index 0, starting from all-ones -> arrays = 0, state IDLE, no acks for 1 cycle after release.
REQ-027 Scenario: fill all 32 indices way B back-to-back -> vbB = 0xFFFFFFFF after 64 cycles; vbA = 0 throughout.
